// File: rtl/if_stage.sv
// if_stage: instruction fetch stage with PC register and IF/ID pipeline register.
//
// Ports
//   clk, rst         : single clock, synchronous active-high reset
//   stall_F          : hold PC and IF/ID (load-use hazard)
//   flush_D          : replace IF/ID with a bubble
//   branch_taken     : redirect fetch to branch_target (resolved in EX)
//   branch_target    : redirect address; low two bits are dropped for fetch
//   imem_addr        : fetch address, always equal to PC
//   imem_rdata       : instruction word for imem_addr, same cycle
//   instr_D, pc_D, pc_plus4_D, valid_D, misalign_D : IF/ID register
//   fetch_count      : valid instructions captured into IF/ID since reset
module if_stage #(
   parameter int                       ADDRESS_WIDTH = 32,
   parameter int                       DATA_WIDTH    = 32,
   parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     stall_F,
   input  logic                     flush_D,
   input  logic                     branch_taken,
   input  logic [ADDRESS_WIDTH-1:0] branch_target,
   output logic [ADDRESS_WIDTH-1:0] imem_addr,
   input  logic [DATA_WIDTH-1:0]    imem_rdata,
   output logic [DATA_WIDTH-1:0]    instr_D,
   output logic [ADDRESS_WIDTH-1:0] pc_D,
   output logic [ADDRESS_WIDTH-1:0] pc_plus4_D,
   output logic                     valid_D,
   output logic                     misalign_D,
   output logic [31:0]              fetch_count
);

   // addi x0,x0,0
   localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

   typedef enum logic {BOOT, RUN} state_t;

   state_t                   state, state_nxt;
   logic [ADDRESS_WIDTH-1:0] pc, pc_nxt, pc_plus4;
   logic                     mis_flag;
   logic                     bubble, capture;

   assign imem_addr = pc;
   assign pc_plus4  = pc + ADDRESS_WIDTH'(4);

   // A redirect always squashes whatever is being fetched this cycle.
   assign bubble  = (state == BOOT) || flush_D || branch_taken;
   assign capture = !bubble && !stall_F;

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      case (state)
         BOOT:    state_nxt = RUN;
         RUN:     state_nxt = RUN;
         default: state_nxt = BOOT;
      endcase
      // PC holds in BOOT so the word at RESET_PC is the first one captured.
      if (branch_taken)
         pc_nxt = {branch_target[ADDRESS_WIDTH-1:2], 2'b00};
      else if (!stall_F && state == RUN)
         pc_nxt = pc_plus4;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= BOOT;
         pc          <= RESET_PC;
         instr_D     <= NOP;
         pc_D        <= '0;
         pc_plus4_D  <= '0;
         valid_D     <= 1'b0;
         misalign_D  <= 1'b0;
         mis_flag    <= 1'b0;
         fetch_count <= '0;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;

         if (bubble) begin
            instr_D    <= NOP;
            pc_D       <= '0;
            pc_plus4_D <= '0;
            valid_D    <= 1'b0;
            misalign_D <= 1'b0;
         end else if (capture) begin
            instr_D     <= imem_rdata;
            pc_D        <= pc;
            pc_plus4_D  <= pc_plus4;
            valid_D     <= 1'b1;
            misalign_D  <= mis_flag;
            fetch_count <= fetch_count + 32'd1;
         end

         // Flag rides until the first valid instruction from the redirected
         // PC picks it up; a later redirect replaces it.
         if (branch_taken)
            mis_flag <= |branch_target[1:0];
         else if (capture)
            mis_flag <= 1'b0;
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: scoreboard bench for if_stage. A cycle model pushes the
// expected IF/ID contents and fetch address before each edge; they are popped
// and compared after the edge. Directed checks cover the named scenarios,
// followed by a random hazard phase. A second instance with RESET_PC at the
// top of the address space checks PC wrap.
module tb_if_stage;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc4;
      logic        valid;
      logic        mis;
      logic [31:0] cnt;
      logic [31:0] addr;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall_F = 1'b0, flush_D = 1'b0, branch_taken = 1'b0;
   logic [31:0] branch_target = '0;
   logic [31:0] imem_addr, imem_rdata, instr_D, pc_D, pc_plus4_D, fetch_count;
   logic        valid_D, misalign_D;
   logic [31:0] imem_addr2, imem_rdata2, instr_D2, pc_D2, pc_plus4_D2, fetch_count2;
   logic        valid_D2, misalign_D2;

   int n_cmp = 0;
   int n_err = 0;

   exp_t        sb_q[$];
   exp_t        cur;
   logic [31:0] m_pc;
   logic        m_boot, m_flag;

   always #5 clk = ~clk;

   // Memory returns the word equal to its address.
   assign imem_rdata  = imem_addr;
   assign imem_rdata2 = imem_addr2;

   if_stage #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst(rst), .stall_F(stall_F), .flush_D(flush_D),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .imem_addr(imem_addr), .imem_rdata(imem_rdata), .instr_D(instr_D),
      .pc_D(pc_D), .pc_plus4_D(pc_plus4_D), .valid_D(valid_D),
      .misalign_D(misalign_D), .fetch_count(fetch_count));

   if_stage #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut2 (
      .clk(clk), .rst(rst), .stall_F(stall_F), .flush_D(flush_D),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .imem_addr(imem_addr2), .imem_rdata(imem_rdata2), .instr_D(instr_D2),
      .pc_D(pc_D2), .pc_plus4_D(pc_plus4_D2), .valid_D(valid_D2),
      .misalign_D(misalign_D2), .fetch_count(fetch_count2));

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, act, exp);
      end
   endtask

   // Cycle model of the fetch stage for the main instance (RESET_PC = 0).
   task automatic model_edge();
      exp_t e = cur;
      if (rst) begin
         m_pc = 32'h0; m_boot = 1'b1; m_flag = 1'b0;
         e.instr = 32'h13; e.pc = 0; e.pc4 = 0; e.valid = 0; e.mis = 0; e.cnt = 0;
      end else begin
         if (m_boot || flush_D || branch_taken) begin
            e.instr = 32'h13; e.pc = 0; e.pc4 = 0; e.valid = 0; e.mis = 0;
         end else if (!stall_F) begin
            e.instr = m_pc; e.pc = m_pc; e.pc4 = m_pc + 32'd4; e.valid = 1;
            e.mis = m_flag; e.cnt = e.cnt + 32'd1; m_flag = 1'b0;
         end
         if (branch_taken) begin
            m_pc   = {branch_target[31:2], 2'b00};
            m_flag = |branch_target[1:0];
         end else if (!m_boot && !stall_F) begin
            m_pc = m_pc + 32'd4;
         end
         m_boot = 1'b0;
      end
      e.addr = m_pc;
      sb_q.push_back(e);
      cur = e;
   endtask

   task automatic step();
      exp_t e;
      model_edge();
      @(posedge clk); #1;
      e = sb_q.pop_front();
      chk("imem_addr",   imem_addr,   e.addr);
      chk("instr_D",     instr_D,     e.instr);
      chk("pc_D",        pc_D,        e.pc);
      chk("pc_plus4_D",  pc_plus4_D,  e.pc4);
      chk("valid_D",     {31'b0, valid_D},    {31'b0, e.valid});
      chk("misalign_D",  {31'b0, misalign_D}, {31'b0, e.mis});
      chk("fetch_count", fetch_count, e.cnt);
   endtask

   initial begin
      cur = '{instr: 32'h13, pc: 0, pc4: 0, valid: 0, mis: 0, cnt: 0, addr: 0};
      m_pc = 0; m_boot = 1; m_flag = 0;
      #1;
      rst = 1'b1; step(); step();
      chk("rst_instr", instr_D, 32'h13);
      chk("rst_valid", {31'b0, valid_D}, 32'd0);
      chk("rst_cnt",   fetch_count, 32'd0);

      // Reset release, straight-line fetch.
      rst = 1'b0;
      chk("boot_addr",  imem_addr,  32'h0);
      chk("boot_addr2", imem_addr2, 32'hFFFF_FFFC);
      step();
      chk("boot_bubble", {31'b0, valid_D}, 32'd0);
      chk("run1_addr",   imem_addr,  32'h0);
      chk("run1_addr2",  imem_addr2, 32'hFFFF_FFFC);
      step();
      chk("first_valid", {31'b0, valid_D}, 32'd1);
      chk("first_pc",    pc_D,    32'h0);
      chk("first_instr", instr_D, 32'h0);
      chk("wrap_addr2",  imem_addr2,  32'h0);
      chk("wrap_pc2",    pc_D2,       32'hFFFF_FFFC);
      chk("wrap_pc4_2",  pc_plus4_D2, 32'h0);
      chk("wrap_valid2", {31'b0, valid_D2}, 32'd1);
      step();
      chk("run2_addr", imem_addr, 32'h8);
      step();
      chk("cnt3", fetch_count, 32'd3);
      step();

      // Two-cycle stall at PC=0x10.
      chk("pre_stall_addr", imem_addr, 32'h10);
      stall_F = 1'b1; step(); step();
      chk("stall_addr", imem_addr, 32'h10);
      chk("stall_pc",   pc_D,      32'hC);
      chk("stall_cnt",  fetch_count, 32'd4);
      stall_F = 1'b0; step();
      chk("resume_pc",   pc_D,      32'h10);
      chk("resume_addr", imem_addr, 32'h14);
      step(); step(); step();

      // Aligned branch from PC=0x20.
      chk("pre_br_addr", imem_addr, 32'h20);
      branch_taken = 1'b1; branch_target = 32'h40; step();
      chk("br_addr",   imem_addr, 32'h40);
      chk("br_bubble", {31'b0, valid_D}, 32'd0);
      branch_taken = 1'b0; step();
      chk("br_pc",  pc_D,       32'h40);
      chk("br_pc4", pc_plus4_D, 32'h44);

      // Misaligned branch coinciding with stall.
      branch_taken = 1'b1; stall_F = 1'b1; branch_target = 32'h82; step();
      chk("mis_addr",   imem_addr, 32'h80);
      chk("mis_bubble", {31'b0, valid_D}, 32'd0);
      branch_taken = 1'b0; stall_F = 1'b0; step();
      chk("mis_pc",  pc_D, 32'h80);
      chk("mis_set", {31'b0, misalign_D}, 32'd1);
      step();
      chk("mis_clr", {31'b0, misalign_D}, 32'd0);

      // Flush alone, then flush with stall.
      flush_D = 1'b1; step();
      stall_F = 1'b1; step();
      flush_D = 1'b0; stall_F = 1'b0; step(); step();

      // Random hazard mix.
      for (int i = 0; i < 200; i++) begin
         branch_taken  = ($urandom_range(0, 7) == 0);
         branch_target = $urandom;
         stall_F       = ($urandom_range(0, 3) == 0);
         flush_D       = ($urandom_range(0, 9) == 0);
         step();
      end
      branch_taken = 1'b0; stall_F = 1'b0; flush_D = 1'b0;
      step(); step();

      // Reset while stalled with a valid instruction held.
      chk("pre_rst_valid", {31'b0, valid_D}, 32'd1);
      stall_F = 1'b1; step();
      rst = 1'b1; branch_taken = 1'b1; branch_target = 32'h123; step();
      chk("rst_mid_valid", {31'b0, valid_D}, 32'd0);
      chk("rst_mid_addr",  imem_addr,   32'h0);
      chk("rst_mid_cnt",   fetch_count, 32'd0);
      chk("rst_mid_instr", instr_D,     32'h13);
      rst = 1'b0; branch_taken = 1'b0; stall_F = 1'b0;
      step(); step(); step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
